// File: rtl/pwm_fade_ctrl.sv
// Purpose: ramps a PWM duty value toward a requested target in steps, updating only at PWM period boundaries.
// Latency: first duty update lands on the (presc+1)-th period start after acceptance; o_done coincides with the final value.
// Backpressure: o_tgt_ready is low while a fade runs, so the requester holds i_tgt_valid until the block returns to IDLE.
module pwm_fade_ctrl #(
   parameter int PWM_BITS   = 8,
   parameter int PRESC_BITS = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_period_start,
   input  logic                  i_tgt_valid,
   output logic                  o_tgt_ready,
   input  logic [PWM_BITS-1:0]   i_tgt_duty,
   input  logic [PWM_BITS-1:0]   i_step,
   input  logic [PRESC_BITS-1:0] i_presc,
   input  logic                  i_abort,
   output logic [PWM_BITS-1:0]   o_duty,
   output logic                  o_busy,
   output logic                  o_done
);

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_t;

   state_t                state;
   logic [PWM_BITS-1:0]   duty_q;
   logic [PWM_BITS-1:0]   tgt_q;
   logic [PWM_BITS-1:0]   step_q;
   logic [PRESC_BITS-1:0] presc_q;
   logic [PRESC_BITS-1:0] cnt_q;
   logic                  up_q;
   logic                  done_q;

   logic [PWM_BITS-1:0]   step_eff;
   logic [PWM_BITS:0]     up_sum;
   logic [PWM_BITS-1:0]   up_next;
   logic [PWM_BITS-1:0]   diff_dn;
   logic [PWM_BITS-1:0]   dn_next;
   logic [PWM_BITS-1:0]   next_duty;

   // Next duty value for an update edge, saturating at the target in either direction.
   always_comb begin
      step_eff  = (step_q == '0) ? PWM_BITS'(1) : step_q;
      // One extra bit so a large step near full scale cannot wrap past the target.
      up_sum    = {1'b0, duty_q} + {1'b0, step_eff};
      up_next   = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[PWM_BITS-1:0];
      // Down ramps only run while duty_q > tgt_q, so this difference never underflows.
      diff_dn   = duty_q - tgt_q;
      dn_next   = (diff_dn < step_eff) ? tgt_q : (duty_q - step_eff);
      next_duty = up_q ? up_next : dn_next;
   end

   // Fade FSM: request latch, prescaled period counting, duty update, done pulse.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state   <= IDLE;
         duty_q  <= '0;
         tgt_q   <= '0;
         step_q  <= '0;
         presc_q <= '0;
         cnt_q   <= '0;
         up_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (i_tgt_valid) begin
                  tgt_q   <= i_tgt_duty;
                  step_q  <= i_step;
                  presc_q <= i_presc;
                  cnt_q   <= '0;
                  if (i_tgt_duty == duty_q) begin
                     // Already at target: finish without ramping.
                     done_q <= 1'b1;
                  end else begin
                     state <= RAMP;
                     up_q  <= (i_tgt_duty > duty_q);
                  end
               end
            end
            RAMP: begin
               if (i_abort) begin
                  // Abort wins over a coincident update; duty stays where it is.
                  state <= IDLE;
                  cnt_q <= '0;
               end else if (i_period_start) begin
                  if (cnt_q != presc_q) begin
                     cnt_q <= cnt_q + PRESC_BITS'(1);
                  end else begin
                     cnt_q  <= '0;
                     duty_q <= next_duty;
                     if (next_duty == tgt_q) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_tgt_ready = (state == IDLE);
   assign o_busy      = (state == RAMP);
   assign o_duty      = duty_q;
   assign o_done      = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: expected duty updates are queued with each request
// and compared by a monitor whenever o_duty changes; direct checks cover handshake and flags.
module tb_pwm_fade_ctrl;

   logic        i_clk;
   logic        i_reset;
   logic        i_period_start;
   logic        i_tgt_valid;
   logic        o_tgt_ready;
   logic [7:0]  i_tgt_duty;
   logic [7:0]  i_step;
   logic [15:0] i_presc;
   logic        i_abort;
   logic [7:0]  o_duty;
   logic        o_busy;
   logic        o_done;

   pwm_fade_ctrl #(.PWM_BITS(8), .PRESC_BITS(16)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_period_start (i_period_start),
      .i_tgt_valid    (i_tgt_valid),
      .o_tgt_ready    (o_tgt_ready),
      .i_tgt_duty     (i_tgt_duty),
      .i_step         (i_step),
      .i_presc        (i_presc),
      .i_abort        (i_abort),
      .o_duty         (o_duty),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   typedef struct {
      logic [7:0] duty;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   done_ref;
   logic [7:0] prev_duty = 8'd0;
   logic       ps_at_edge = 1'b0;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Remember whether the last rising edge carried a period-start pulse.
   always @(posedge i_clk) ps_at_edge <= i_period_start;

   // Scoreboard monitor: every duty change must match the next queued expectation.
   always @(negedge i_clk) begin
      if (o_done === 1'b1) done_cnt++;
      if (i_reset) begin
         prev_duty = o_duty;
      end else if (o_duty !== prev_duty) begin
         check("duty_change_on_period_start", {31'd0, ps_at_edge}, 32'd1);
         if (exp_q.size() == 0) begin
            check("unexpected_duty_change", {24'd0, o_duty}, {24'd0, prev_duty});
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_duty", {24'd0, o_duty}, {24'd0, e.duty});
            check("sb_done", {31'd0, o_done}, {31'd0, e.done});
         end
         prev_duty = o_duty;
      end
   end

   task automatic push_exp(input logic [7:0] d, input logic dn);
      exp_t e;
      e.duty = d;
      e.done = dn;
      exp_q.push_back(e);
   endtask

   task automatic request(input logic [7:0] t, input logic [7:0] s, input logic [15:0] p);
      i_tgt_valid = 1'b1;
      i_tgt_duty  = t;
      i_step      = s;
      i_presc     = p;
      @(negedge i_clk);
      i_tgt_valid = 1'b0;
   endtask

   task automatic pulse(input int n);
      for (int k = 0; k < n; k++) begin
         i_period_start = 1'b1;
         @(negedge i_clk);
         i_period_start = 1'b0;
         @(negedge i_clk);
      end
   endtask

   initial begin
      i_reset        = 1'b1;
      i_period_start = 1'b0;
      i_tgt_valid    = 1'b0;
      i_tgt_duty     = 8'd0;
      i_step         = 8'd0;
      i_presc        = 16'd0;
      i_abort        = 1'b0;

      // Reset state
      @(negedge i_clk);
      check("rst_duty", {24'd0, o_duty}, 32'd0);
      check("rst_ready", {31'd0, o_tgt_ready}, 32'd1);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);
      @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);

      // Up ramp 0 -> 10, step 4, presc 0
      push_exp(8'd4, 1'b0);
      push_exp(8'd8, 1'b0);
      push_exp(8'd10, 1'b1);
      done_ref = done_cnt;
      request(8'd10, 8'd4, 16'd0);
      check("up_busy", {31'd0, o_busy}, 32'd1);
      check("up_ready_low", {31'd0, o_tgt_ready}, 32'd0);
      repeat (3) @(negedge i_clk);
      check("up_hold_no_period", {24'd0, o_duty}, 32'd0);
      pulse(1);
      check("up_first", {24'd0, o_duty}, 32'd4);
      pulse(2);
      check("up_final", {24'd0, o_duty}, 32'd10);
      check("up_ready_after", {31'd0, o_tgt_ready}, 32'd1);
      check("up_done_once", done_cnt - done_ref, 32'd1);

      // Jump to 200 in one saturating update
      push_exp(8'd200, 1'b1);
      request(8'd200, 8'd200, 16'd0);
      pulse(1);
      check("jump_200", {24'd0, o_duty}, 32'd200);

      // Down ramp 200 -> 190, step 3, presc 2
      push_exp(8'd197, 1'b0);
      push_exp(8'd194, 1'b0);
      push_exp(8'd191, 1'b0);
      push_exp(8'd190, 1'b1);
      done_ref = done_cnt;
      request(8'd190, 8'd3, 16'd2);
      pulse(2);
      check("dn_prescale_hold", {24'd0, o_duty}, 32'd200);
      pulse(1);
      check("dn_first", {24'd0, o_duty}, 32'd197);
      // A request presented during RAMP must not be taken.
      i_tgt_valid = 1'b1;
      i_tgt_duty  = 8'd50;
      i_step      = 8'd1;
      i_presc     = 16'd0;
      @(negedge i_clk);
      check("ramp_ready_low", {31'd0, o_tgt_ready}, 32'd0);
      @(negedge i_clk);
      i_tgt_valid = 1'b0;
      pulse(9);
      check("dn_final", {24'd0, o_duty}, 32'd190);
      check("dn_idle", {31'd0, o_busy}, 32'd0);
      check("dn_done_once", done_cnt - done_ref, 32'd1);

      // Saturation near full scale
      push_exp(8'd250, 1'b1);
      request(8'd250, 8'd60, 16'd0);
      pulse(1);
      push_exp(8'd255, 1'b1);
      request(8'd255, 8'd16, 16'd0);
      pulse(1);
      check("sat_255", {24'd0, o_duty}, 32'd255);
      // Step of 0 behaves as 1
      push_exp(8'd254, 1'b0);
      push_exp(8'd253, 1'b1);
      request(8'd253, 8'd0, 16'd0);
      pulse(1);
      check("step0_first", {24'd0, o_duty}, 32'd254);
      pulse(1);
      check("step0_final", {24'd0, o_duty}, 32'd253);

      // Equal target: no ramp, done next cycle
      done_ref = done_cnt;
      request(8'd253, 8'd5, 16'd0);
      check("eq_done", {31'd0, o_done}, 32'd1);
      check("eq_busy", {31'd0, o_busy}, 32'd0);
      @(negedge i_clk);
      check("eq_done_drop", {31'd0, o_done}, 32'd0);
      check("eq_duty", {24'd0, o_duty}, 32'd253);
      check("eq_done_once", done_cnt - done_ref, 32'd1);

      // Abort in IDLE is ignored
      i_abort = 1'b1;
      @(negedge i_clk);
      i_abort = 1'b0;
      check("abort_idle_ready", {31'd0, o_tgt_ready}, 32'd1);

      // Abort coincident with an update period start
      push_exp(8'd243, 1'b0);
      done_ref = done_cnt;
      request(8'd100, 8'd10, 16'd0);
      pulse(1);
      check("abort_pre", {24'd0, o_duty}, 32'd243);
      i_abort        = 1'b1;
      i_period_start = 1'b1;
      @(negedge i_clk);
      i_abort        = 1'b0;
      i_period_start = 1'b0;
      check("abort_duty", {24'd0, o_duty}, 32'd243);
      check("abort_idle", {31'd0, o_busy}, 32'd0);
      check("abort_no_done", {31'd0, o_done}, 32'd0);
      pulse(2);
      check("abort_hold", {24'd0, o_duty}, 32'd243);
      check("abort_done_cnt", done_cnt - done_ref, 32'd0);

      // Async reset in the middle of a ramp
      request(8'd0, 8'd1, 16'd5);
      pulse(1);
      check("pre_rst_busy", {31'd0, o_busy}, 32'd1);
      @(posedge i_clk);
      #3;
      i_reset = 1'b1;
      #1;
      check("arst_duty", {24'd0, o_duty}, 32'd0);
      check("arst_busy", {31'd0, o_busy}, 32'd0);
      check("arst_ready", {31'd0, o_tgt_ready}, 32'd1);
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);
      check("arst_no_done", done_cnt - done_ref, 32'd0);
      push_exp(8'd5, 1'b1);
      request(8'd5, 8'd5, 16'd0);
      check("post_rst_busy", {31'd0, o_busy}, 32'd1);
      pulse(1);
      check("post_rst_duty", {24'd0, o_duty}, 32'd5);
      @(negedge i_clk);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, width of duty values (matches attached PWM generator).
REQ-002 SHALL have parameter PRESC_BITS, default 16, width of the period prescaler.
REQ-003 SHALL have port i_clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_period_start  input  1  one-cycle pulse marking the start of each PWM period (counter wrap).
REQ-006 SHALL have port i_tgt_valid  input  1  fade request valid.
REQ-007 SHALL have port o_tgt_ready  output  1  fade request accepted when high with i_tgt_valid.
REQ-008 SHALL have port i_tgt_duty  input  PWM_BITS  target duty value.
REQ-009 SHALL have port i_step  input  PWM_BITS  duty change per update.
REQ-010 SHALL have port i_presc  input  PRESC_BITS  PWM periods between updates, minus one.
REQ-011 SHALL have port i_abort  input  1  stop the active fade, hold current duty.
REQ-012 SHALL have port o_duty  output  PWM_BITS  registered duty value driving the PWM generator.
REQ-013 SHALL have port o_busy  output  1  high while a fade is in progress.
REQ-014 SHALL have port o_done  output  1  one-cycle pulse when o_duty reaches the target.

Function
REQ-015 SHALL implement two states: IDLE and RAMP; o_tgt_ready = (state == IDLE); o_busy = (state == RAMP).
REQ-016 SHALL, in IDLE on i_tgt_valid & o_tgt_ready, latch i_tgt_duty, i_step, i_presc and clear the prescale counter on that edge.
REQ-017 SHALL treat a latched step of 0 as step 1.
REQ-018 SHALL, on acceptance with target == o_duty, remain in IDLE and assert o_done in the following cycle; o_duty unchanged.
REQ-019 SHALL, on acceptance with target != o_duty, enter RAMP on the next edge; direction (up/down) fixed at acceptance.
REQ-020 SHALL, in RAMP, act only on cycles with i_period_start high; o_duty never changes on other cycles (glitch-free duty at period boundary).
REQ-021 SHALL, on i_period_start in RAMP with prescale counter != latched presc, increment the counter and hold o_duty.
REQ-022 SHALL, on i_period_start in RAMP with prescale counter == latched presc, clear the counter and update o_duty on that edge.
REQ-023 SHALL compute up-updates in PWM_BITS+1 width: o_duty <= min(o_duty + step, target); no wrap past 2^PWM_BITS-1.
REQ-024 SHALL compute down-updates saturating: o_duty <= (o_duty - target < step) ? target : o_duty - step; never below target or 0.
REQ-025 SHALL, on the edge where the updated o_duty equals target, return to IDLE and assert o_done for exactly one cycle, coincident with the final o_duty value.
REQ-026 SHALL give latch-to-first-update latency of (presc+1) i_period_start pulses after entering RAMP.
REQ-027 SHALL, on i_abort in RAMP, return to IDLE on that edge, hold o_duty, clear counter, not assert o_done.
REQ-028 SHALL give i_abort priority over a coincident update edge (no duty change that cycle).
REQ-029 SHALL ignore i_abort in IDLE; i_tgt_valid in RAMP is not accepted (held by requester).

Reset
REQ-030 SHALL, on i_reset high, asynchronously force state IDLE, o_duty = 0, prescale counter = 0, latched registers = 0, o_done = 0.
REQ-031 SHALL, therefore, present o_tgt_ready = 1, o_busy = 0 during and after reset; reset mid-RAMP abandons the fade without o_done.

Verification
REQ-032 SHALL cover up-ramp: o_duty=0, request tgt=10 step=4 presc=0 -> o_duty 4, 8, 10 on three successive period starts, o_done with 10, then ready=1.
REQ-033 SHALL cover down-ramp with prescale: o_duty=200, tgt=190 step=3 presc=2 -> updates every 3rd period start: 197, 194, 191, 190; o_done once.
REQ-034 SHALL cover saturation: PWM_BITS=8, o_duty=250, tgt=255 step=16 -> single update to 255, no wrap; step=0 request -> advances by 1.
REQ-035 SHALL cover equal target: tgt == o_duty -> no RAMP, o_busy stays 0, o_done pulse next cycle.
REQ-036 SHALL cover abort: abort asserted on the same cycle as an update period start -> o_duty unchanged, IDLE next cycle, no o_done.
REQ-037 SHALL cover async reset asserted mid-RAMP between clock edges -> o_duty = 0, o_busy = 0 immediately; new request accepted after release.
